// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong score/game-state logic.
package pong_pkg;

  localparam int unsigned DIG_W = 4;

  typedef enum logic [1:0] {
    ST_NEWGAME,
    ST_PLAY,
    ST_NEWBALL,
    ST_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  // Two-digit BCD increment returning {tens, ones}; 99 wraps to 00.
  function automatic logic [2*DIG_W-1:0] bcd2_inc(input logic [DIG_W-1:0] tens,
                                                  input logic [DIG_W-1:0] ones);
    logic [DIG_W-1:0] t;
    logic [DIG_W-1:0] o;
    if (ones == DIG_W'(9)) begin
      o = '0;
      t = (tens == DIG_W'(9)) ? '0 : tens + DIG_W'(1);
    end else begin
      o = ones + DIG_W'(1);
      t = tens;
    end
    return {t, o};
  endfunction

endpackage

// File: rtl/pong_bcd2.sv
// Two-digit BCD score counter with synchronous clear (priority) and increment.
module pong_bcd2
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [DIG_W-1:0] dig0,
  output logic [DIG_W-1:0] dig1
);

  logic [DIG_W-1:0] dig0_q, dig0_d;
  logic [DIG_W-1:0] dig1_q, dig1_d;

  always_comb begin
    dig0_d = dig0_q;
    dig1_d = dig1_q;
    if (clr) begin
      dig0_d = '0;
      dig1_d = '0;
    end else if (inc) begin
      {dig1_d, dig0_d} = bcd2_inc(dig1_q, dig0_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig0_q <= '0;
      dig1_q <= '0;
    end else begin
      dig0_q <= dig0_d;
      dig1_q <= dig1_d;
    end
  end

  assign dig0 = dig0_q;
  assign dig1 = dig1_q;

endmodule

// File: rtl/pong_score_ctrl.sv
// Pong game-state FSM, pause timer and BCD score keeping for both players.
module pong_score_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned TIMER_TICKS = 120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refr_tick,
  input  logic             btn_start,
  input  logic             miss_a,
  input  logic             miss_b,
  output logic [DIG_W-1:0] dig0_A,
  output logic [DIG_W-1:0] dig1_A,
  output logic [DIG_W-1:0] dig0_B,
  output logic [DIG_W-1:0] dig1_B,
  output logic             graph_still,
  output logic             show_rule,
  output logic             show_over,
  output logic [1:0]       winner
);

  localparam logic [DIG_W-1:0] WIN_ONES   = DIG_W'(WIN_SCORE % 10);
  localparam logic [DIG_W-1:0] WIN_TENS   = DIG_W'(WIN_SCORE / 10);
  localparam logic [6:0]       TIMER_LOAD = 7'(TIMER_TICKS);

  state_t     state_q, state_d;
  logic [6:0] timer_q, timer_d;
  logic [1:0] winner_q, winner_d;
  logic       graph_still_q, show_rule_q, show_over_q;
  logic       clr, inc_a, inc_b;
  logic [2*DIG_W-1:0] a_next, b_next;

  pong_bcd2 u_score_a (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc_a),
    .dig0  (dig0_A),
    .dig1  (dig1_A)
  );

  pong_bcd2 u_score_b (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc_b),
    .dig0  (dig0_B),
    .dig1  (dig1_B)
  );

  // Win is judged on the post-increment value so it lands on the same edge as the point.
  assign a_next = bcd2_inc(dig1_A, dig0_A);
  assign b_next = bcd2_inc(dig1_B, dig0_B);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    winner_d = winner_q;
    clr      = 1'b0;
    inc_a    = 1'b0;
    inc_b    = 1'b0;
    case (state_q)
      ST_NEWGAME: begin
        clr      = 1'b1;
        winner_d = WIN_NONE;
        if (btn_start) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (miss_a && miss_b) begin
          state_d = ST_NEWBALL;
          timer_d = TIMER_LOAD;
        end else if (miss_b) begin
          inc_a   = 1'b1;
          timer_d = TIMER_LOAD;
          if (a_next == {WIN_TENS, WIN_ONES}) begin
            state_d  = ST_OVER;
            winner_d = WIN_A;
          end else begin
            state_d = ST_NEWBALL;
          end
        end else if (miss_a) begin
          inc_b   = 1'b1;
          timer_d = TIMER_LOAD;
          if (b_next == {WIN_TENS, WIN_ONES}) begin
            state_d  = ST_OVER;
            winner_d = WIN_B;
          end else begin
            state_d = ST_NEWBALL;
          end
        end
      end
      ST_NEWBALL: begin
        if (timer_q != '0) begin
          if (refr_tick) timer_d = timer_q - 7'd1;
        end else if (btn_start) begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (timer_q != '0) begin
          if (refr_tick) timer_d = timer_q - 7'd1;
        end else begin
          state_d = ST_NEWGAME;
        end
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_NEWGAME;
      timer_q       <= '0;
      winner_q      <= WIN_NONE;
      graph_still_q <= 1'b1;
      show_rule_q   <= 1'b1;
      show_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      winner_q      <= winner_d;
      graph_still_q <= (state_d != ST_PLAY);
      show_rule_q   <= (state_d == ST_NEWGAME);
      show_over_q   <= (state_d == ST_OVER);
    end
  end

  assign graph_still = graph_still_q;
  assign show_rule   = show_rule_q;
  assign show_over   = show_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Self-checking bench for pong_score_ctrl: vector table, directed corner sequences, random vs model.
module tb_pong_score_ctrl;

  localparam int unsigned WIN = 11;
  localparam int unsigned TT  = 3;

  localparam int M_NEWGAME = 0;
  localparam int M_PLAY    = 1;
  localparam int M_NEWBALL = 2;
  localparam int M_OVER    = 3;

  logic       clk = 1'b0;
  logic       reset, refr_tick, btn_start, miss_a, miss_b;
  logic [3:0] dig0_A, dig1_A, dig0_B, dig1_B;
  logic       graph_still, show_rule, show_over;
  logic [1:0] winner;

  pong_score_ctrl #(.WIN_SCORE(WIN), .TIMER_TICKS(TT)) dut (
    .clk         (clk),
    .reset       (reset),
    .refr_tick   (refr_tick),
    .btn_start   (btn_start),
    .miss_a      (miss_a),
    .miss_b      (miss_b),
    .dig0_A      (dig0_A),
    .dig1_A      (dig1_A),
    .dig0_B      (dig0_B),
    .dig1_B      (dig1_B),
    .graph_still (graph_still),
    .show_rule   (show_rule),
    .show_over   (show_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: integer scores, a mode code and a pause counter.
  int m_a, m_b, m_mode, m_timer, m_win;

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_mode = M_NEWGAME; m_timer = 0; m_win = 0;
  endfunction

  function automatic void model_step(input logic r, input logic b, input logic ma, input logic mb);
    case (m_mode)
      M_NEWGAME: begin
        m_a = 0; m_b = 0; m_win = 0;
        if (b) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (ma && mb) begin
          m_mode = M_NEWBALL; m_timer = TT;
        end else if (mb) begin
          m_a = (m_a + 1) % 100; m_timer = TT;
          if (m_a == WIN) begin m_mode = M_OVER; m_win = 1; end
          else m_mode = M_NEWBALL;
        end else if (ma) begin
          m_b = (m_b + 1) % 100; m_timer = TT;
          if (m_b == WIN) begin m_mode = M_OVER; m_win = 2; end
          else m_mode = M_NEWBALL;
        end
      end
      M_NEWBALL: begin
        if (m_timer == 0) begin
          if (b) m_mode = M_PLAY;
        end else if (r) m_timer--;
      end
      default: begin
        if (m_timer == 0) m_mode = M_NEWGAME;
        else if (r) m_timer--;
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " dig0_A"}, 32'(dig0_A), m_a % 10);
    chk({tag, " dig1_A"}, 32'(dig1_A), m_a / 10);
    chk({tag, " dig0_B"}, 32'(dig0_B), m_b % 10);
    chk({tag, " dig1_B"}, 32'(dig1_B), m_b / 10);
    chk({tag, " graph_still"}, 32'(graph_still), 32'(m_mode != M_PLAY));
    chk({tag, " show_rule"}, 32'(show_rule), 32'(m_mode == M_NEWGAME));
    chk({tag, " show_over"}, 32'(show_over), 32'(m_mode == M_OVER));
    chk({tag, " winner"}, 32'(winner), m_win);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " dig0_A"}, 32'(dig0_A), 0);
    chk({tag, " dig1_A"}, 32'(dig1_A), 0);
    chk({tag, " dig0_B"}, 32'(dig0_B), 0);
    chk({tag, " dig1_B"}, 32'(dig1_B), 0);
    chk({tag, " graph_still"}, 32'(graph_still), 1);
    chk({tag, " show_rule"}, 32'(show_rule), 1);
    chk({tag, " show_over"}, 32'(show_over), 0);
    chk({tag, " winner"}, 32'(winner), 0);
  endtask

  // One active edge: model samples the same inputs as the DUT, then outputs are read 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step(refr_tick, btn_start, miss_a, miss_b);
    #1;
  endtask

  task automatic pulse(input logic ma, input logic mb, input string tag);
    miss_a = ma; miss_b = mb;
    tick();
    miss_a = 1'b0; miss_b = 1'b0;
    check_all(tag);
  endtask

  task automatic skip_pause(input string tag);
    btn_start = 1'b1; refr_tick = 1'b1;
    for (int k = 0; k < int'(TT); k++) begin
      tick();
      check_all({tag, " pause"});
    end
    refr_tick = 1'b0;
    tick();
    check_all({tag, " resume"});
    btn_start = 1'b0;
  endtask

  typedef struct {
    logic       refr, btn, ma, mb;
    int         a, b;
    logic       gs, sr, so;
    logic [1:0] win;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00}; // start -> PLAY
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 2'b00}; // A scores -> NEWBALL
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 2'b00}; // timer 3->2
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 2'b00}; // 2->1
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 2'b00}; // 1->0
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 2'b00}; // timer 0 + btn -> PLAY
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0, 2'b00}; // B scores
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0, 2'b00}; // misses ignored in NEWBALL

    refr_tick = 1'b0; btn_start = 1'b0; miss_a = 1'b0; miss_b = 1'b0;
    reset = 1'b1;
    model_reset();
    #3;
    chk_reset_vals("por");
    #20 reset = 1'b0;
    tick();
    check_all("idle newgame");

    for (int i = 0; i < 8; i++) begin
      refr_tick = tbl[i].refr; btn_start = tbl[i].btn;
      miss_a = tbl[i].ma; miss_b = tbl[i].mb;
      tick();
      chk($sformatf("vec%0d dig0_A", i), 32'(dig0_A), tbl[i].a % 10);
      chk($sformatf("vec%0d dig1_A", i), 32'(dig1_A), tbl[i].a / 10);
      chk($sformatf("vec%0d dig0_B", i), 32'(dig0_B), tbl[i].b % 10);
      chk($sformatf("vec%0d graph_still", i), 32'(graph_still), 32'(tbl[i].gs));
      chk($sformatf("vec%0d show_rule", i), 32'(show_rule), 32'(tbl[i].sr));
      chk($sformatf("vec%0d show_over", i), 32'(show_over), 32'(tbl[i].so));
      chk($sformatf("vec%0d winner", i), 32'(winner), 32'(tbl[i].win));
      check_all($sformatf("vec%0d model", i));
    end
    refr_tick = 1'b0; btn_start = 1'b0; miss_a = 1'b0; miss_b = 1'b0;

    // Full game for A: BCD carry at 10, win at 11, further misses ignored.
    reset = 1'b1; #2;
    chk_reset_vals("async reset 1");
    tick();
    reset = 1'b0;
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    chk("run start graph_still", 32'(graph_still), 0);
    chk("run start show_rule", 32'(show_rule), 0);
    for (int i = 1; i <= 11; i++) begin
      pulse(1'b0, 1'b1, $sformatf("run pt%0d", i));
      chk($sformatf("run pt%0d ones", i), 32'(dig0_A), i % 10);
      chk($sformatf("run pt%0d tens", i), 32'(dig1_A), i / 10);
      if (i < int'(WIN)) skip_pause($sformatf("run pt%0d", i));
    end
    chk("run win show_over", 32'(show_over), 1);
    chk("run win winner", 32'(winner), 1);
    pulse(1'b0, 1'b1, "over miss ignored");

    refr_tick = 1'b1;
    for (int k = 0; k < int'(TT); k++) begin
      tick();
      chk($sformatf("over tick%0d show_over", k), 32'(show_over), 1);
      check_all("over pause");
    end
    refr_tick = 1'b0;
    tick();
    chk("over exit show_rule", 32'(show_rule), 1);
    chk("over exit score hold", 32'(dig0_A), 1);
    check_all("over exit");
    tick();
    chk("newgame clr dig0_A", 32'(dig0_A), 0);
    chk("newgame clr dig1_A", 32'(dig1_A), 0);
    chk("newgame clr winner", 32'(winner), 0);
    check_all("newgame clr");

    // Dead rally, then exact NEWBALL exit with btn held.
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    pulse(1'b1, 1'b1, "dead rally");
    chk("dead rally graph_still", 32'(graph_still), 1);
    chk("dead rally dig0_A", 32'(dig0_A), 0);
    chk("dead rally dig0_B", 32'(dig0_B), 0);
    btn_start = 1'b1; refr_tick = 1'b1;
    for (int k = 0; k < int'(TT); k++) begin
      tick();
      chk($sformatf("newball hold%0d graph_still", k), 32'(graph_still), 1);
    end
    tick();
    chk("newball exit graph_still", 32'(graph_still), 0);
    check_all("newball exit");
    btn_start = 1'b0; refr_tick = 1'b0;

    // Reach 5-7 in PLAY, then reset between edges.
    for (int i = 0; i < 5; i++) begin
      pulse(1'b0, 1'b1, "pre5 a");
      skip_pause("pre5 a");
    end
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1, 1'b0, "pre7 b");
      skip_pause("pre7 b");
    end
    chk("pre-reset dig0_A", 32'(dig0_A), 5);
    chk("pre-reset dig0_B", 32'(dig0_B), 7);
    chk("pre-reset graph_still", 32'(graph_still), 0);
    #3 reset = 1'b1;
    #1;
    chk_reset_vals("mid-game async reset");
    model_reset();
    tick();
    reset = 1'b0;
    tick();
    check_all("post reset");

    for (int n = 0; n < 3000; n++) begin
      refr_tick = 1'($urandom_range(0, 1));
      btn_start = ($urandom_range(0, 3) == 0);
      miss_a    = ($urandom_range(0, 5) == 0);
      miss_b    = ($urandom_range(0, 5) == 0);
      tick();
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_score_ctrl.md
# pong_score_ctrl

Game-state and score keeper for the two-player pong display. It receives one-cycle miss events from the ball/paddle graphics logic and keeps two 2-digit BCD scores. It also runs the game state machine (new game, play, new ball, game over) and drives the score digits, freeze, overlay-select and winner signals. Those outputs go to the text overlay renderer and the graphics logic.

## Interface
Parameters:
- WIN_SCORE, 11, points that end the game; legal range 1..99
- TIMER_TICKS, 120, refresh ticks of pause after a point and after game over (2 s at 60 Hz); legal range 1..127

Ports:
- clk  in  1  system clock; every register is clocked on the rising edge
- reset  in  1  asynchronous, active-high; all registers clear at once
- refr_tick  in  1  one-cycle pulse, once per video frame
- btn_start  in  1  level input; high while any player button is pressed
- miss_a  in  1  one-cycle pulse; ball passed paddle A, so B scores
- miss_b  in  1  one-cycle pulse; ball passed paddle B, so A scores
- dig0_A, dig1_A  out  4 each  player A ones/tens BCD digits
- dig0_B, dig1_B  out  4 each  player B ones/tens BCD digits
- graph_still  out  1  freezes ball motion; high in every state except PLAY
- show_rule  out  1  high in NEWGAME only (rule/logo overlay)
- show_over  out  1  high in OVER only (GAME OVER overlay)
- winner  out  2  01 = A won, 10 = B won, 00 = no winner

## Operation
- States: NEWGAME, PLAY, NEWBALL, OVER. Reset state is NEWGAME.
- NEWGAME:
  - All four digits and winner are cleared every cycle.
  - btn_start = 1 moves to PLAY.
- PLAY, single miss:
  - miss_b alone adds 1 to A's score.
  - miss_a alone adds 1 to B's score.
  - If the new score equals WIN_SCORE: go to OVER, set winner to that player, load timer.
  - Otherwise: go to NEWBALL, load timer.
- PLAY, simultaneous miss:
  - miss_a and miss_b high in the same cycle count as a dead rally.
  - No score changes. Go to NEWBALL and load timer.
- NEWBALL:
  - Timer decrements on each refr_tick while it is nonzero.
  - When timer == 0 and btn_start = 1, go to PLAY.
  - Miss pulses are ignored.
- OVER:
  - Timer decrements as in NEWBALL.
  - When timer == 0, go to NEWGAME, ignoring btn_start.
  - Scores and winner hold until NEWGAME clears them.
- BCD increment:
  - If the ones digit is 9, ones becomes 0 and tens increments; otherwise ones increments.
  - 99 + 1 wraps to 00. This cannot happen because WIN_SCORE ≤ 99.
- Win compare: {tens, ones} after increment equals {WIN_SCORE/10, WIN_SCORE%10}, with both constants computed at elaboration time.
- Timer is 7 bits and loads TIMER_TICKS on the transition edge. The pause is exactly TIMER_TICKS refresh ticks.

## Timing
- Every output is a registered output.
- Reset values:
  - all digits 0, winner 00, timer 0
  - graph_still 1, show_rule 1, show_over 0
- Miss latency: a miss pulse sampled at edge n updates the digit, state, winner and the graph_still/show_over outputs all at edge n. The renderer sees the new score in the cycle after the pulse.
- A refr_tick and a state-entry timer load in the same cycle: the load wins.
- NEWBALL exit: btn_start held high through the pause gives PLAY on the first edge where timer == 0.
- A reset asserted mid-game returns to the reset values immediately, with no clock edge needed. Operation resumes in NEWGAME on the first edge after reset is released.

## Structure
- Shared package pong_pkg holds:
  - state enum (NEWGAME, PLAY, NEWBALL, OVER)
  - BCD digit width constant (4)
  - winner encodings
- One sub-module, pong_bcd2: two-digit BCD counter.
  - Inputs: clk, reset, clr, inc.
  - Outputs: dig0, dig1.
  - Instantiated once for A and once for B.
- The FSM, timer and win compare live in pong_score_ctrl.

## Test plan
- Reset then release: all outputs at reset values; btn_start pulse moves to PLAY, so graph_still=0 and show_rule=0.
- In PLAY, 12 separated miss_b pulses (timer pauses skipped with btn_start, TIMER_TICKS=3): A digits run 0…9, then 10 and 11 via the BCD carry; the 11th point gives show_over=1 and winner=01.
- In PLAY, miss_a and miss_b in the same cycle: both scores unchanged, state NEWBALL, graph_still=1.
- NEWBALL with btn_start held: PLAY is reached exactly after 3 refr_ticks (TIMER_TICKS=3), never earlier.
- OVER: after 3 refr_ticks, NEWGAME is reached; digits become 00/00 and winner 00 on the next edge.
- Reset asserted between clock edges during PLAY with score 5–7: outputs clear asynchronously before the next edge.
